// File: rtl/cache_pmem_arbiter.sv
// Shares one physical-memory port between I-cache fills and D-cache fills/write-backs.
// One transaction at a time; ties are granted round-robin, D first out of reset.
module cache_pmem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_addr,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_addr,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_addr,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] I_BUSY  = 2'd1;
    localparam logic [1:0] D_BUSY  = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic [1:0]            state, state_n;
    logic                  last_grant, last_grant_n;
    logic                  read_n, write_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [LINE_WIDTH-1:0] wdata_n;
    logic                  i_req, d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // Next-state, grant and latched pmem command.
    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        read_n       = pmem_read;
        write_n      = pmem_write;
        addr_n       = pmem_addr;
        wdata_n      = pmem_wdata;
        case (state)
            IDLE: begin
                if (d_req && (!i_req || last_grant == GRANT_I)) begin
                    state_n      = D_BUSY;
                    last_grant_n = GRANT_D;
                    // Simultaneous read and write from D is served as a write.
                    write_n      = d_pmem_write;
                    read_n       = ~d_pmem_write;
                    addr_n       = d_pmem_addr;
                    if (d_pmem_write) begin
                        wdata_n = d_pmem_wdata;
                    end
                end else if (i_req) begin
                    state_n      = I_BUSY;
                    last_grant_n = GRANT_I;
                    read_n       = 1'b1;
                    write_n      = 1'b0;
                    addr_n       = i_pmem_addr;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_n = RELEASE;
                    read_n  = 1'b0;
                    write_n = 1'b0;
                end
            end
            RELEASE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                read_n  = 1'b0;
                write_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            pmem_addr  <= '0;
            pmem_wdata <= '0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            pmem_read  <= read_n;
            pmem_write <= write_n;
            pmem_addr  <= addr_n;
            pmem_wdata <= wdata_n;
        end
    end

    // Completion is forwarded in the same cycle only to the current owner.
    assign i_pmem_resp  = (state == I_BUSY) && pmem_resp;
    assign d_pmem_resp  = (state == D_BUSY) && pmem_resp;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// Directed bench for cache_pmem_arbiter: single I read, D write-back, tie-break,
// round-robin contention, reset mid-transaction and stray pmem_resp.
module tb_cache_pmem_arbiter;

    logic         clk;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_addr;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_addr;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_addr;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int checks   = 0;
    int failures = 0;

    cache_pmem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_pmem_read  (i_pmem_read),
        .i_pmem_addr  (i_pmem_addr),
        .i_pmem_rdata (i_pmem_rdata),
        .i_pmem_resp  (i_pmem_resp),
        .d_pmem_read  (d_pmem_read),
        .d_pmem_write (d_pmem_write),
        .d_pmem_addr  (d_pmem_addr),
        .d_pmem_wdata (d_pmem_wdata),
        .d_pmem_rdata (d_pmem_rdata),
        .d_pmem_resp  (d_pmem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_addr    (pmem_addr),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [255:0] LINE_A5 = {32{8'hA5}};
    localparam logic [255:0] LINE_12 = {8{32'h12345678}};
    localparam logic [255:0] LINE_DE = {8{32'hDEADBEEF}};
    localparam logic [255:0] LINE_3C = {32{8'h3C}};

    initial begin
        logic exp_d;
        rst = 1'b1;
        i_pmem_read = 1'b0; i_pmem_addr = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_addr = '0; d_pmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        #1;
        tick(); tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_pmem_read",  256'(pmem_read),  256'(0));
        chk("rst_pmem_write", 256'(pmem_write), 256'(0));
        chk("rst_pmem_addr",  256'(pmem_addr),  256'(0));
        chk("rst_pmem_wdata", pmem_wdata, 256'(0));
        chk("rst_i_resp",     256'(i_pmem_resp), 256'(0));
        chk("rst_d_resp",     256'(d_pmem_resp), 256'(0));

        // Single I read
        i_pmem_read = 1'b1; i_pmem_addr = 32'h0000_0040;
        tick();
        chk("i1_pmem_read", 256'(pmem_read), 256'(1));
        chk("i1_pmem_addr", 256'(pmem_addr), 256'(32'h40));
        chk("i1_pmem_write", 256'(pmem_write), 256'(0));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("i1_read_held", 256'(pmem_read), 256'(1));
            chk("i1_no_early_resp", 256'(i_pmem_resp), 256'(0));
        end
        pmem_resp = 1'b1; pmem_rdata = LINE_A5;
        #1;
        chk("i1_i_resp",  256'(i_pmem_resp), 256'(1));
        chk("i1_i_rdata", i_pmem_rdata, LINE_A5);
        chk("i1_d_resp",  256'(d_pmem_resp), 256'(0));
        chk("i1_read_in_resp", 256'(pmem_read), 256'(1));
        tick();
        chk("i1_i_resp_once", 256'(i_pmem_resp), 256'(0));
        pmem_resp = 1'b0; i_pmem_read = 1'b0;
        #1;
        chk("i1_release_read", 256'(pmem_read), 256'(0));
        tick();
        tick();

        // D write-back with wdata changed mid-transaction
        d_pmem_write = 1'b1; d_pmem_addr = 32'h0000_1000; d_pmem_wdata = LINE_12;
        tick();
        chk("dw_pmem_write", 256'(pmem_write), 256'(1));
        chk("dw_pmem_read",  256'(pmem_read),  256'(0));
        chk("dw_pmem_addr",  256'(pmem_addr),  256'(32'h1000));
        d_pmem_wdata = LINE_DE; d_pmem_addr = 32'h0000_9999;
        tick();
        chk("dw_wdata_latched", pmem_wdata, LINE_12);
        chk("dw_addr_latched",  256'(pmem_addr), 256'(32'h1000));
        tick();
        pmem_resp = 1'b1;
        #1;
        chk("dw_d_resp", 256'(d_pmem_resp), 256'(1));
        chk("dw_i_resp", 256'(i_pmem_resp), 256'(0));
        tick();
        pmem_resp = 1'b0; d_pmem_write = 1'b0;
        #1;
        chk("dw_d_resp_once", 256'(d_pmem_resp), 256'(0));
        chk("dw_release_write", 256'(pmem_write), 256'(0));
        tick();

        // Simultaneous I and D reads out of reset: D first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_pmem_read = 1'b1; i_pmem_addr = 32'h80;
        d_pmem_read = 1'b1; d_pmem_addr = 32'h2000;
        tick();
        chk("tie_first_addr", 256'(pmem_addr), 256'(32'h2000));
        chk("tie_first_read", 256'(pmem_read), 256'(1));
        tick();
        pmem_resp = 1'b1; pmem_rdata = LINE_3C;
        #1;
        chk("tie_d_resp",  256'(d_pmem_resp), 256'(1));
        chk("tie_d_rdata", d_pmem_rdata, LINE_3C);
        chk("tie_i_wait",  256'(i_pmem_resp), 256'(0));
        tick();
        pmem_resp = 1'b0; d_pmem_read = 1'b0;
        #1;
        chk("tie_release_gap", 256'(pmem_read), 256'(0));
        tick();
        chk("tie_idle_gap", 256'(pmem_read), 256'(0));
        tick();
        chk("tie_second_read", 256'(pmem_read), 256'(1));
        chk("tie_second_addr", 256'(pmem_addr), 256'(32'h80));
        pmem_resp = 1'b1;
        #1;
        chk("tie_i_resp", 256'(i_pmem_resp), 256'(1));
        chk("tie_d_quiet", 256'(d_pmem_resp), 256'(0));
        tick();
        pmem_resp = 1'b0;
        #1;
        tick();

        // Continuous contention: grants alternate D, I, D, I
        i_pmem_addr = 32'h300; d_pmem_read = 1'b1; d_pmem_addr = 32'h400;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 0);
            tick();
            chk("rr_addr", 256'(pmem_addr), exp_d ? 256'(32'h400) : 256'(32'h300));
            tick();
            pmem_resp = 1'b1;
            #1;
            chk("rr_d_resp", 256'(d_pmem_resp), 256'(exp_d));
            chk("rr_i_resp", 256'(i_pmem_resp), 256'(!exp_d));
            tick();
            pmem_resp = 1'b0;
            #1;
            tick();
        end
        i_pmem_read = 1'b0; d_pmem_read = 1'b0;
        tick();

        // Reset during D_BUSY before pmem_resp
        d_pmem_read = 1'b1; d_pmem_addr = 32'h500;
        tick();
        chk("rb_busy_read", 256'(pmem_read), 256'(1));
        chk("rb_busy_addr", 256'(pmem_addr), 256'(32'h500));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; d_pmem_read = 1'b0;
        pmem_resp = 1'b1;
        #1;
        chk("rb_read_dropped", 256'(pmem_read), 256'(0));
        chk("rb_no_d_resp", 256'(d_pmem_resp), 256'(0));
        pmem_resp = 1'b0;
        i_pmem_read = 1'b1; i_pmem_addr = 32'h600;
        tick();
        chk("rb_fresh_read", 256'(pmem_read), 256'(1));
        chk("rb_fresh_addr", 256'(pmem_addr), 256'(32'h600));
        pmem_resp = 1'b1;
        #1;
        chk("rb_fresh_i_resp", 256'(i_pmem_resp), 256'(1));
        tick();
        pmem_resp = 1'b0; i_pmem_read = 1'b0;
        tick();
        tick();

        // Stray pmem_resp in IDLE
        pmem_resp = 1'b1;
        #1;
        chk("stray_i_resp", 256'(i_pmem_resp), 256'(0));
        chk("stray_d_resp", 256'(d_pmem_resp), 256'(0));
        tick();
        chk("stray_no_cmd", 256'(pmem_read), 256'(0));
        pmem_resp = 1'b0;
        d_pmem_read = 1'b1; d_pmem_addr = 32'h700;
        tick();
        chk("stray_still_idle", 256'(pmem_read), 256'(1));
        chk("stray_next_addr",  256'(pmem_addr), 256'(32'h700));
        pmem_resp = 1'b1;
        #1;
        chk("stray_next_resp", 256'(d_pmem_resp), 256'(1));
        tick();
        pmem_resp = 1'b0; d_pmem_read = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
